// File: rtl/fir_mac_core_if.sv
// fir_mac_core_if
// Bundles the coefficient write port, the sample input stream and the
// result output stream between the register block (master) and the
// MAC engine (slave). Parameters must match those of the core instance.

interface fir_mac_core_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 32
);
   localparam int ADDR_W = $clog2(TAPS);

   logic              coef_wr_en;
   logic [ADDR_W-1:0] coef_addr;
   logic [COEF_W-1:0] coef_wdata;
   logic              coef_wr_err;
   logic              clear_hist;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_ready;
   logic              busy;

   // Register block side: drives requests, observes status and results
   modport master (
      output coef_wr_en, coef_addr, coef_wdata, clear_hist,
      output in_valid, in_data, out_ready,
      input  coef_wr_err, in_ready, out_valid, out_data, busy
   );

   // MAC engine side
   modport slave (
      input  coef_wr_en, coef_addr, coef_wdata, clear_hist,
      input  in_valid, in_data, out_ready,
      output coef_wr_err, in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fir_mac_core.sv
// fir_mac_core
// Sequential TAPS-point FIR engine with a single signed multiplier.
// One sample is accepted in IDLE, TAPS multiply-accumulate cycles follow,
// and the result is held in OUT until the consumer takes it.
// Optional feature macro: FIR_MAC_SAT_EN -- when defined, the result is
// saturated to the signed OUT_W range; otherwise it wraps (truncates).

module fir_mac_core #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 32
) (
   input logic           ACLK,
   input logic           ARESET,
   fir_mac_core_if.slave bus
);
   localparam int ADDR_W = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(TAPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_OUT
   } state_t;

   state_t                   state;
   logic signed [COEF_W-1:0] coef [TAPS];
   logic signed [DATA_W-1:0] hist [TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0]        k;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [OUT_W-1:0]         acc_out;

   logic                     in_ready_q;
   logic                     out_valid_q;
   logic [OUT_W-1:0]         out_data_q;
   logic                     coef_wr_err_q;
   logic                     busy_q;

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.coef_wr_err = coef_wr_err_q;
   assign bus.busy        = busy_q;

   // Current tap product and the running sum including it
   always_comb begin
      prod    = coef[k] * hist[k];
      acc_sum = acc + ACC_W'(prod);
   end

   // Conversion of the final sum to the output width
   generate
      if (ACC_W <= OUT_W) begin : g_extend
         assign acc_out = OUT_W'(acc_sum);
      end else begin : g_narrow
`ifdef FIR_MAC_SAT_EN
         logic overflow;
         assign overflow = (acc_sum[ACC_W-1:OUT_W-1] !=
                            {(ACC_W-OUT_W+1){acc_sum[ACC_W-1]}});
         assign acc_out  = !overflow       ? acc_sum[OUT_W-1:0] :
                           acc_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                              {1'b0, {(OUT_W-1){1'b1}}};
`else
         assign acc_out = acc_sum[OUT_W-1:0];
`endif
      end
   endgenerate

   // Control FSM, coefficient/history storage and registered outputs
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state         <= S_IDLE;
         acc           <= '0;
         k             <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         coef_wr_err_q <= 1'b0;
         busy_q        <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            coef[i] <= '0;
            hist[i] <= '0;
         end
      end else begin
         coef_wr_err_q <= 1'b0;
         if (bus.coef_wr_en) begin
            if (state == S_IDLE) begin
               coef[bus.coef_addr] <= bus.coef_wdata;
            end else begin
               coef_wr_err_q <= 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (in_ready_q && bus.in_valid) begin
                  hist[0] <= bus.in_data;
                  for (int i = 1; i < TAPS; i++) begin
                     hist[i] <= bus.clear_hist ? '0 : hist[i-1];
                  end
                  acc        <= '0;
                  k          <= '0;
                  state      <= S_MAC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  if (bus.clear_hist) begin
                     for (int i = 0; i < TAPS; i++) begin
                        hist[i] <= '0;
                     end
                  end
                  in_ready_q <= 1'b1;
               end
            end

            S_MAC: begin
               acc <= acc_sum;
               k   <= k + 1'b1;
               if (k == ADDR_W'(TAPS-1)) begin
                  state       <= S_OUT;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_out;
               end
            end

            S_OUT: begin
               if (bus.out_ready) begin
                  state       <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
